// File: rtl/video_pkg.sv
// Shared raster timing defaults, scan-out state encoding and counter sizing helper.
package video_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // 8:8:8 RGB pixel and a row buffer deep enough for half a visible line
  localparam int DEF_S = 24;
  localparam int DEF_A = 9;

  // IDLE: after reset, nothing but the frame pre-fetch may fire.
  // ARMED: the back bank holds a requested row, so row swaps are meaningful.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } scan_state_t;

  // Bits needed for a counter running 0..total-1
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/row_scanout_if.sv
// Read/control port between the scan-out engine and the ping-pong row buffer.
interface row_scanout_if
  import video_pkg::*;
#(
  parameter int A = DEF_A,
  parameter int S = DEF_S
);
  logic [A-1:0] address_read;
  logic [S-1:0] data_read;
  logic         swap;
  logic         row_request;
  logic [A-1:0] row_index;

  // Scan-out side drives the address and the row protocol
  modport master (
    output address_read, swap, row_request, row_index,
    input  data_read
  );

  // Buffer side returns pixel data one clock after the address
  modport slave (
    input  address_read, swap, row_request, row_index,
    output data_read
  );
endinterface

// File: rtl/video_timing.sv
// Horizontal/vertical raster counters with raw (unregistered) sync and visible flags.
module video_timing
  import video_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int HW = cnt_width(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
  parameter int VW = cnt_width(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [HW-1:0] h,
  output logic [HW-1:0] h_next,
  output logic [VW-1:0] v_next,
  output logic          visible,
  output logic          hsync_raw,
  output logic          vsync_raw
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  // Next raster position: h wraps every line, v steps on each h wrap
  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == HW'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
    end
  end

  // Position registers; reset restarts the raster at the top-left pixel
  always_ff @(posedge clock) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h      = h_q;
  // Un-reset next position: the row protocol registers its pulses from it
  assign h_next = h_d;
  assign v_next = v_d;

  assign visible   = (h_q < HW'(H_VISIBLE)) && (v_q < VW'(V_VISIBLE));
  assign hsync_raw = !((h_q >= HW'(H_VISIBLE + H_FRONT)) &&
                       (h_q <  HW'(H_VISIBLE + H_FRONT + H_SYNC)));
  assign vsync_raw = !((v_q >= VW'(V_VISIBLE + V_FRONT)) &&
                       (v_q <  VW'(V_VISIBLE + V_FRONT + V_SYNC)));

endmodule

// File: rtl/row_scanout.sv
// Raster scan-out from a ping-pong row buffer: 2x2 pixel replication, row
// pre-fetch protocol and a one-stage output pipeline matching the read latency.
module row_scanout
  import video_pkg::*;
#(
  parameter int A         = DEF_A,
  parameter int S         = DEF_S,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic          clock,
  input  logic          reset,
  row_scanout_if.master buf_if,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [S-1:0]  rgb
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int ROWS    = V_VISIBLE / 2;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);

  logic [HW-1:0] h, h_next;
  logic [VW-1:0] v_next;
  logic          visible, hsync_raw, vsync_raw;

  video_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clock    (clock),
    .reset    (reset),
    .h        (h),
    .h_next   (h_next),
    .v_next   (v_next),
    .visible  (visible),
    .hsync_raw(hsync_raw),
    .vsync_raw(vsync_raw)
  );

  // Each stored pixel covers two clocks; blanking parks the address at 0
  assign buf_if.address_read = visible ? A'(h >> 1) : '0;

  // Row protocol is decoded on the upcoming position so the registered
  // pulses line up exactly with the counter values they belong to.
  logic [VW-1:0] row_next;
  logic          at_line_start, at_line_end, in_rows, has_next_row;

  assign row_next      = v_next >> 1;
  assign at_line_start = (h_next == '0);
  assign at_line_end   = (h_next == HW'(H_TOTAL - 1));
  assign in_rows       = (v_next < VW'(V_VISIBLE));
  assign has_next_row  = (row_next < VW'(ROWS - 1));

  scan_state_t  state_q, state_d;
  logic         swap_q, swap_d;
  logic         req_q, req_d;
  logic [A-1:0] idx_q, idx_d;

  // Next-state and pulse decode: the frame pre-fetch arms the engine, then
  // even lines request the following row and odd lines swap it in.
  always_comb begin
    state_d = state_q;
    swap_d  = 1'b0;
    req_d   = 1'b0;
    idx_d   = idx_q;
    if (at_line_start && (v_next == VW'(V_TOTAL - 2))) begin
      req_d   = 1'b1;
      idx_d   = '0;
      state_d = ST_ARMED;
    end else if (state_q == ST_ARMED) begin
      if (at_line_start && in_rows && !v_next[0] && has_next_row) begin
        req_d = 1'b1;
        idx_d = A'(row_next) + A'(1);
      end
      if (at_line_end && ((v_next == VW'(V_TOTAL - 1)) ||
                          (in_rows && v_next[0] && has_next_row))) begin
        swap_d = 1'b1;
      end
    end
  end

  // Protocol state and pulse registers; reset drops any pulse in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      swap_q  <= 1'b0;
      req_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      swap_q  <= swap_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
    end
  end

  assign buf_if.swap        = swap_q;
  assign buf_if.row_request = req_q;
  assign buf_if.row_index   = idx_q;

  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;

  // Stage-1 inputs are the timing flags of the address issued this clock
  always_comb begin
    hsync_d = hsync_raw;
    vsync_d = vsync_raw;
    de_d    = visible;
  end

  // Delay the flags by the buffer's read latency so they meet their pixel
  always_ff @(posedge clock) begin
    if (reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  // Buffer data is already registered; blank it outside the active area
  assign rgb   = de_q ? buf_if.data_read : '0;

endmodule

// File: tb/tb_row_scanout.sv
// Directed bench for row_scanout: a reduced raster with a bank-swapping buffer
// model, plus a full-width 640-pixel raster with few lines for period checks.
module tb_row_scanout;
  import video_pkg::*;

  localparam int A = 9;
  localparam int S = 24;

  logic clk   = 1'b0;
  logic rst_s = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  row_scanout_if #(.A(A), .S(S)) bus_s ();
  row_scanout_if #(.A(A), .S(S)) bus_b ();

  logic         hs_s, vs_s, de_s, hs_b, vs_b, de_b;
  logic [S-1:0] rgb_s, rgb_b;

  row_scanout #(
    .A(A), .S(S),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .clock(clk), .reset(rst_s), .buf_if(bus_s),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .rgb(rgb_s)
  );

  row_scanout #(
    .A(A), .S(S),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(3)
  ) u_big (
    .clock(clk), .reset(rst_b), .buf_if(bus_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb(rgb_b)
  );

  // Ping-pong buffer model: data = {row in display bank, address}
  logic [A-1:0] disp_row = 9'd5;
  logic [A-1:0] back_row = 9'd6;
  always @(posedge clk) begin
    bus_s.data_read <= S'({disp_row, bus_s.address_read});
    if (bus_s.swap) begin
      disp_row <= back_row;
      back_row <= disp_row;
    end else if (bus_s.row_request) begin
      back_row <= bus_s.row_index;
    end
  end

  // Always-nonzero data so blanking of rgb is observable
  always @(posedge clk) bus_b.data_read <= 24'hA50000 | S'(bus_b.address_read);

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  initial begin
    int first_low, low_cnt, sw_n, rq_n, de_l0, rgb_bad, spur;
    int sw_v[2], sw_h[2], rq_v[2], rq_h[2], rq_i[2];
    int h, v, ph, pv;
    int last_hf, hs_pmin, hs_pmax, hs_falls, vf0, vf1, run;
    int de_min, de_max, de_lines, sw_w, rq_w, bad_b;
    logic hs_l, vs_l, de_l, in_win;

    // ---------------- reset values ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsync",   32'(hs_s), 1);
    chk("rst_vsync",   32'(vs_s), 1);
    chk("rst_de",      32'(de_s), 0);
    chk("rst_rgb",     32'(rgb_s), 0);
    chk("rst_swap",    32'(bus_s.swap), 0);
    chk("rst_req",     32'(bus_s.row_request), 0);
    chk("rst_idx",     32'(bus_s.row_index), 0);
    chk("rst_addr",    32'(bus_s.address_read), 0);
    chk("rst_b_hsync", 32'(hs_b), 1);
    chk("rst_b_de",    32'(de_b), 0);

    // ---------------- first hsync after release ----------------
    rst_s = 1'b0;
    k = 0;
    first_low = -1;
    low_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (!hs_s) begin
        if (first_low < 0) first_low = k;
        low_cnt++;
      end
    end
    chk("hsync_first_low", 32'(first_low), 11);
    chk("hsync_low_len",   32'(low_cnt), 2);

    // ---------------- steady frame (frame 1) ----------------
    while (k < 97) step();
    sw_n = 0; rq_n = 0; de_l0 = 0; rgb_bad = 0;
    for (int i = 0; i < 2; i++) begin
      sw_v[i] = -1; sw_h[i] = -1; rq_v[i] = -1; rq_h[i] = -1; rq_i[i] = -1;
    end
    repeat (98) begin
      step();
      h  = k % 14;        v  = (k / 14) % 7;
      ph = (k - 1) % 14;  pv = ((k - 1) / 14) % 7;
      if (bus_s.swap) begin
        if (sw_n < 2) begin sw_v[sw_n] = v; sw_h[sw_n] = h; end
        sw_n++;
      end
      if (bus_s.row_request) begin
        if (rq_n < 2) begin rq_v[rq_n] = v; rq_h[rq_n] = h; rq_i[rq_n] = 32'(bus_s.row_index); end
        rq_n++;
      end
      if (!de_s && rgb_s != '0) rgb_bad++;
      if (pv == 0 && de_s) de_l0++;
      if (pv < 3 && ph < 8)
        chk($sformatf("rgb_l%0d_p%0d", pv, ph), 32'(rgb_s), ((pv / 2) << 9) | (ph / 2));
    end
    chk("line0_de_len", 32'(de_l0), 8);
    chk("frame_swaps",  32'(sw_n), 2);
    chk("frame_reqs",   32'(rq_n), 2);
    chk("req0_idx",     32'(rq_i[0]), 1);
    chk("req0_v",       32'(rq_v[0]), 0);
    chk("req0_h",       32'(rq_h[0]), 0);
    chk("req1_idx",     32'(rq_i[1]), 0);
    chk("req1_v",       32'(rq_v[1]), 5);
    chk("swap0_v",      32'(sw_v[0]), 1);
    chk("swap0_h",      32'(sw_h[0]), 13);
    chk("swap1_v",      32'(sw_v[1]), 6);
    chk("swap1_h",      32'(sw_h[1]), 13);
    chk("rgb_blank_s",  32'(rgb_bad), 0);

    // ---------------- reset at h=5, v=2 ----------------
    while (k < 229) step();
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    chk("mid_rst_swap", 32'(bus_s.swap), 0);
    chk("mid_rst_req",  32'(bus_s.row_request), 0);
    chk("mid_rst_de",   32'(de_s), 0);
    chk("mid_rst_addr", 32'(bus_s.address_read), 0);
    spur = 32'(bus_s.swap) + 32'(bus_s.row_request);
    step();
    chk("post_rst_de",  32'(de_s), 1);
    spur += 32'(bus_s.swap) + 32'(bus_s.row_request);
    step();
    chk("post_rst_addr", 32'(bus_s.address_read), 1);
    spur += 32'(bus_s.swap) + 32'(bus_s.row_request);
    while (k < 299) begin
      step();
      spur += 32'(bus_s.swap) + 32'(bus_s.row_request);
    end
    chk("post_rst_spurious", 32'(spur), 0);
    step();
    chk("prefetch_req", 32'(bus_s.row_request), 1);
    chk("prefetch_idx", 32'(bus_s.row_index), 0);

    // ---------------- full-width raster ----------------
    rst_b = 1'b0;
    hs_l = 1'b1; vs_l = 1'b1; de_l = 1'b0;
    last_hf = -1; hs_pmin = 1 << 30; hs_pmax = 0; hs_falls = 0;
    vf0 = -1; vf1 = -1; run = 0; de_min = 1 << 30; de_max = 0;
    de_lines = 0; sw_w = 0; rq_w = 0; bad_b = 0;
    for (int j = 1; j <= 24000; j++) begin
      @(posedge clk);
      #1;
      if (hs_l && !hs_b) begin
        if (last_hf >= 0) begin
          if (j - last_hf < hs_pmin) hs_pmin = j - last_hf;
          if (j - last_hf > hs_pmax) hs_pmax = j - last_hf;
        end
        last_hf = j;
        hs_falls++;
      end
      if (vs_l && !vs_b) begin
        if (vf0 < 0) vf0 = j;
        else if (vf1 < 0) vf1 = j;
      end
      in_win = (vf0 >= 0) && (vf1 < 0);
      if (de_b) begin
        run++;
      end else if (de_l) begin
        if (run < de_min) de_min = run;
        if (run > de_max) de_max = run;
        if (in_win) de_lines++;
        run = 0;
      end
      if (in_win && bus_b.swap) sw_w++;
      if (in_win && bus_b.row_request) rq_w++;
      if (!de_b && rgb_b != '0) bad_b++;
      hs_l = hs_b; vs_l = vs_b; de_l = de_b;
    end
    chk("hsync_period_min", 32'(hs_pmin), 800);
    chk("hsync_period_max", 32'(hs_pmax), 800);
    chk("hsync_falls",      32'(hs_falls), 30);
    chk("vsync_period",     32'(vf1 - vf0), 11200);
    chk("de_len_min",       32'(de_min), 640);
    chk("de_len_max",       32'(de_max), 640);
    chk("de_lines",         32'(de_lines), 8);
    chk("big_swaps",        32'(sw_w), 4);
    chk("big_reqs",         32'(rq_w), 4);
    chk("rgb_blank_b",      32'(bad_b), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
